// File: rtl/adder_share_sched.sv
// Round-robin sequencer sharing one external 8-bit adder between NREQ requesters, byte-serial LSB first.
// Optional macro ADDER_SHARE_SCHED_OVF_EN adds the rsp_ovf signed-overflow output.
module adder_share_sched #(
  parameter int NREQ   = 2,
  parameter int NBYTES = 4,
  localparam int W     = 8 * NBYTES,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_ci,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic              add_ci,
  input  logic [7:0]        add_s,
  input  logic              add_co,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_co,
  output logic              busy
`ifdef ADDER_SHARE_SCHED_OVF_EN
  ,
  output logic              rsp_ovf
`endif
);

  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rrPtr_q;
  logic [BW-1:0]   byteIdx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [IDW-1:0]  id_q;
  logic            co_q;
  logic            ovf_q;

  logic [IDW-1:0]  grantIdx;
  logic            grantFound;
  logic            accept;

  // Search starts at rrPtr_q so the requester served last has lowest priority next time.
  always_comb begin
    int unsigned   cand;
    logic [IDW-1:0] candIdx;
    cand       = 0;
    candIdx    = '0;
    grantIdx   = '0;
    grantFound = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand    = (int'(rrPtr_q) + k) % NREQ;
      candIdx = IDW'(cand);
      if (!grantFound && req_valid[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  assign accept = (state_q == IDLE) && grantFound && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grantIdx] = 1'b1;
  end

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = a_q[8*byteIdx_q +: 8];
      add_b  = b_q[8*byteIdx_q +: 8];
      add_ci = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      byteIdx_q <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      id_q      <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            a_q       <= req_a[int'(grantIdx)*W +: W];
            b_q       <= req_b[int'(grantIdx)*W +: W];
            carry_q   <= req_ci[grantIdx];
            id_q      <= grantIdx;
            byteIdx_q <= '0;
            rrPtr_q   <= (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          sum_q[8*byteIdx_q +: 8] <= add_s;
          carry_q                 <= add_co;
          if (byteIdx_q == LAST_BYTE) begin
            co_q      <= add_co;
            // The top byte's sum bit is the W-bit result's sign bit.
            ovf_q     <= (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
            byteIdx_q <= '0;
            state_q   <= DONE;
          end else begin
            byteIdx_q <= byteIdx_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == DONE) && !rst;
  assign busy      = (state_q != IDLE) && !rst;
  assign rsp_co    = co_q && !rst;
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

`ifdef ADDER_SHARE_SCHED_OVF_EN
  assign rsp_ovf = ovf_q && !rst;
`else
  logic unusedOvf;
  assign unusedOvf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed self-checking bench for adder_share_sched with a behavioural model of the shared adder.
module tb_adder_share_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0]  req_ci = '0;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_ci;
  logic [7:0]  add_s;
  logic        add_co;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_co;
  logic        busy;
`ifdef ADDER_SHARE_SCHED_OVF_EN
  logic        rsp_ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  logic [8:0] addFull;
  assign addFull = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_ci};
  assign add_s   = addFull[7:0];
  assign add_co  = addFull[8];

  adder_share_sched #(.NREQ(2), .NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_co(rsp_co),
    .busy(busy)
`ifdef ADDER_SHARE_SCHED_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    tick();
    tick();
    compared++;
    if (req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); end
    compared++;
    if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst       = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    compared++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL idle_outputs: busy=%b rsp_valid=%b req_ready=%b expected 0/0/00", busy, rsp_valid, req_ready);
    end
    compared++;
    if (add_a !== 8'h00 || add_b !== 8'h00 || add_ci !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_adder_inputs: a=%h b=%h ci=%b expected 00/00/0", add_a, add_b, add_ci);
    end
  endtask

  task automatic test_ripple_carry();
    int n;
    req_a[31:0] = 32'h00FF_FFFF;
    req_b[31:0] = 32'h0000_0001;
    req_ci[0]   = 1'b0;
    req_valid   = 2'b01;
    #1;
    compared++;
    if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL single_grant: got %b expected 01", req_ready); end
    tick();
    n = 1;
    req_valid = 2'b00;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    compared++;
    if (n !== 5) begin mismatched++; $display("[TB] FAIL single_latency: got %0d expected 5", n); end
    compared++;
    if (rsp_sum !== 32'h0100_0000) begin mismatched++; $display("[TB] FAIL single_sum: got %h expected 01000000", rsp_sum); end
    compared++;
    if (rsp_co !== 1'b0 || rsp_id !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_co_id: co=%b id=%0d expected 0/0", rsp_co, rsp_id);
    end
`ifdef ADDER_SHARE_SCHED_OVF_EN
    compared++;
    if (rsp_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL single_ovf: got %b expected 0", rsp_ovf); end
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_release: rsp_valid=%b busy=%b expected 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_carry_in_wrap();
    int n;
    req_a[63:32] = 32'hFFFF_FFFF;
    req_b[63:32] = 32'h0000_0000;
    req_ci[1]    = 1'b1;
    req_valid    = 2'b10;
    #1;
    compared++;
    if (req_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL wrap_grant: got %b expected 10", req_ready); end
    tick();
    n = 1;
    req_valid = 2'b00;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    compared++;
    if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_timeout: rsp_valid=%b after %0d cycles expected 1", rsp_valid, n); end
    compared++;
    if (rsp_sum !== 32'h0000_0000 || rsp_co !== 1'b1 || rsp_id !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wrap_result: sum=%h co=%b id=%0d expected 00000000/1/1", rsp_sum, rsp_co, rsp_id);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_ci    = 2'b00;
  endtask

  task automatic test_round_robin();
    int          ids[4];
    logic [31:0] sums[4];
    int          got;
    int          n;
    got       = 0;
    n         = 0;
    req_a     = {32'd10, 32'd1};
    req_b     = {32'd20, 32'd2};
    req_ci    = 2'b00;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    while (got < 4 && n < 80) begin
      tick();
      n++;
      if (rsp_valid) begin
        ids[got]  = int'(rsp_id);
        sums[got] = rsp_sum;
        got++;
        if (got == 4) req_valid = 2'b00;
      end
    end
    compared++;
    if (got !== 4) begin mismatched++; $display("[TB] FAIL rr_count: got %0d responses expected 4", got); end
    for (int i = 0; i < got; i++) begin
      compared++;
      if (ids[i] !== (i % 2)) begin mismatched++; $display("[TB] FAIL rr_id%0d: got %0d expected %0d", i, ids[i], i % 2); end
      compared++;
      if (sums[i] !== ((i % 2) ? 32'd30 : 32'd3)) begin
        mismatched++;
        $display("[TB] FAIL rr_sum%0d: got %0d expected %0d", i, sums[i], (i % 2) ? 30 : 3);
      end
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    int n;
    int extra;
    req_a[31:0] = 32'h1234_5678;
    req_b[31:0] = 32'h1111_1111;
    req_ci      = 2'b00;
    req_valid   = 2'b01;
    rsp_ready   = 1'b0;
    tick();
    n = 1;
    req_valid = 2'b10;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h2345_6789 || rsp_id !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL bp_hold%0d: valid=%b sum=%h id=%0d expected 1/23456789/0", i, rsp_valid, rsp_sum, rsp_id);
      end
      compared++;
      if (req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL bp_ready%0d: got %b expected 00", i, req_ready); end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    extra = 0;
    repeat (8) begin
      if (rsp_valid) extra++;
      tick();
    end
    compared++;
    if (extra !== 0) begin mismatched++; $display("[TB] FAIL bp_single_rsp: got %0d extra cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int extra;
    req_a[63:32] = 32'h0102_0304;
    req_b[63:32] = 32'h0000_0000;
    req_valid    = 2'b10;
    #1;
    compared++;
    if (req_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL mid_grant: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    compared++;
    if (add_a !== 8'h02) begin mismatched++; $display("[TB] FAIL mid_byte2: add_a=%h expected 02", add_a); end
    rst = 1'b1;
    tick();
    compared++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_abort: busy=%b rsp_valid=%b expected 0/0", busy, rsp_valid);
    end
    rst = 1'b0;
    extra = 0;
    repeat (8) begin
      tick();
      if (rsp_valid || busy) extra++;
    end
    compared++;
    if (extra !== 0) begin mismatched++; $display("[TB] FAIL mid_no_rsp: got %0d active cycles expected 0", extra); end

    req_a[31:0] = 32'h7FFF_FFFF;
    req_b[31:0] = 32'h0000_0001;
    req_ci      = 2'b00;
    req_valid   = 2'b01;
    #1;
    compared++;
    if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL post_reset_grant: got %b expected 01", req_ready); end
    tick();
    n = 1;
    req_valid = 2'b00;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    compared++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h8000_0000 || rsp_co !== 1'b0 || rsp_id !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_result: valid=%b sum=%h co=%b id=%0d expected 1/80000000/0/0", rsp_valid, rsp_sum, rsp_co, rsp_id);
    end
`ifdef ADDER_SHARE_SCHED_OVF_EN
    compared++;
    if (rsp_ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf: got %b expected 1", rsp_ovf); end
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ripple_carry();
    test_carry_in_wrap();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
